// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: decode redirect, global stall, decode output and instruction SRAM port.
interface if_fetch_if;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;

   // Fetch stage side.
   modport master (
      input  stall,
      input  br_bus,
      output if_to_id_bus,
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata
   );

   // Pipeline control / SRAM / decode side.
   modport slave (
      output stall,
      output br_bus,
      input  if_to_id_bus,
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction SRAM read port, and keeps a
// redirect that arrives during a stall so it is applied when the stall drops.
//
// state     | meaning
// ----------+-------------------------------------------------
// BOOT      | after reset, nothing fetched yet (ce=0)
// RUN       | fetching, PC advances or redirects every cycle
// HOLD      | stalled, no redirect waiting
// HOLD_PEND | stalled, a redirect is waiting in pend_addr
module if_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   if_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      BOOT      = 2'd0,
      RUN       = 2'd1,
      HOLD      = 2'd2,
      HOLD_PEND = 2'd3
   } state_t;

   // Reset PC sits one word below the vector so the first sequential step lands on it.
   localparam logic [31:0] RESET_PC = RESET_VECTOR - 32'd4;

   state_t      state;
   logic [31:0] pc_r;
   logic        ce_r;
   logic        pend_v;
   logic [31:0] pend_addr;

   logic        pc_stop;
   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] next_pc;
   logic        stall_unused;

   assign pc_stop      = bus.stall[0];
   assign br_e         = bus.br_bus[32];
   assign br_addr      = bus.br_bus[31:0];
   assign stall_unused = ^bus.stall[5:1];

   // Live redirect beats a stored one, which beats the sequential step.
   always_comb begin
      next_pc = pc_r + 32'd4;
      if (br_e)
         next_pc = br_addr;
      else if (pend_v)
         next_pc = pend_addr;
   end

   // PC / pending-redirect FSM; every output comes straight from these registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BOOT;
         pc_r      <= RESET_PC;
         ce_r      <= 1'b0;
         pend_v    <= 1'b0;
         pend_addr <= 32'h0;
      end else if (!pc_stop) begin
         pc_r   <= next_pc;
         ce_r   <= 1'b1;
         pend_v <= 1'b0;
         state  <= RUN;
      end else begin
         case (state)
            BOOT: ;
            RUN, HOLD, HOLD_PEND: begin
               if (br_e) begin
                  pend_v    <= 1'b1;
                  pend_addr <= br_addr;
                  state     <= HOLD_PEND;
               end else if (state == RUN) begin
                  state <= HOLD;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   assign bus.if_to_id_bus    = {ce_r, pc_r};
   assign bus.inst_sram_en    = ce_r;
   assign bus.inst_sram_wen   = 4'b0000;
   assign bus.inst_sram_addr  = pc_r;
   assign bus.inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: each cycle's stimulus pushes the expected fetch onto a queue,
// which is popped and compared just after the clock edge.
module tb_if_fetch;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   if_fetch_if bus ();

   if_fetch #(.RESET_VECTOR(32'hBFC0_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [32:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle, queue what the SRAM port must show after the edge, then compare.
   task automatic step(input string tag, input logic r, input logic st0, input logic be,
                       input logic [31:0] ba, input logic exp_ce, input logic [31:0] exp_addr);
      logic [32:0] e;
      rst        = r;
      bus.stall  = {5'b10101, st0};
      bus.br_bus = {be, ba};
      exp_q.push_back({exp_ce, exp_addr});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_bus"},  64'(bus.if_to_id_bus), 64'(e));
         chk({tag, "_en"},   64'(bus.inst_sram_en), 64'(e[32]));
         chk({tag, "_addr"}, 64'(bus.inst_sram_addr), 64'(e[31:0]));
      end
      bus.br_bus = 33'h0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst        = 1'b1;
      bus.stall  = 6'h0;
      bus.br_bus = 33'h0;

      step("reset0", 1, 0, 0, 32'h0, 0, 32'hBFBF_FFFC);
      step("reset1", 1, 0, 1, 32'h8000_0040, 0, 32'hBFBF_FFFC);
      chk("wen", 64'(bus.inst_sram_wen), 64'h0);
      chk("wdata", 64'(bus.inst_sram_wdata), 64'h0);

      // Sequential fetch from the reset vector.
      step("boot", 0, 0, 0, 32'h0, 1, 32'hBFC0_0000);
      step("seq4", 0, 0, 0, 32'h0, 1, 32'hBFC0_0004);
      step("seq8", 0, 0, 0, 32'h0, 1, 32'hBFC0_0008);
      step("seqC", 0, 0, 0, 32'h0, 1, 32'hBFC0_000C);
      step("seq10", 0, 0, 0, 32'h0, 1, 32'hBFC0_0010);

      // Unstalled redirect.
      step("br100", 0, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0100);
      step("br104", 0, 0, 0, 32'h0, 1, 32'hBFC0_0104);

      // Plain stall for three cycles at BFC0_0020.
      step("to20", 0, 0, 1, 32'hBFC0_0020, 1, 32'hBFC0_0020);
      for (int i = 0; i < 3; i++)
         step("hold20", 0, 1, 0, 32'h0, 1, 32'hBFC0_0020);
      step("rel24", 0, 0, 0, 32'h0, 1, 32'hBFC0_0024);

      // Redirect captured during stall cycle 2, applied on release.
      step("to30", 0, 0, 1, 32'hBFC0_0030, 1, 32'hBFC0_0030);
      step("st1", 0, 1, 0, 32'h0, 1, 32'hBFC0_0030);
      step("st2br", 0, 1, 1, 32'h8000_0040, 1, 32'hBFC0_0030);
      step("st3", 0, 1, 0, 32'h0, 1, 32'hBFC0_0030);
      step("st4", 0, 1, 0, 32'h0, 1, 32'hBFC0_0030);
      step("pend40", 0, 0, 0, 32'h0, 1, 32'h8000_0040);
      step("pend44", 0, 0, 0, 32'h0, 1, 32'h8000_0044);

      // Pending redirect overridden by a live one at release; pending must not resurface.
      step("cap40", 0, 1, 1, 32'h8000_0040, 1, 32'h8000_0044);
      step("hold44", 0, 1, 0, 32'h0, 1, 32'h8000_0044);
      step("live80", 0, 0, 1, 32'h8000_0080, 1, 32'h8000_0080);
      step("seq84", 0, 0, 0, 32'h0, 1, 32'h8000_0084);

      // Latest redirect wins while stalled.
      step("ow1", 0, 1, 1, 32'h8000_0200, 1, 32'h8000_0084);
      step("ow2", 0, 1, 1, 32'h8000_0300, 1, 32'h8000_0084);
      step("ow_rel", 0, 0, 0, 32'h0, 1, 32'h8000_0300);

      // Unaligned redirect passes through.
      step("unal", 0, 0, 1, 32'h8000_0402, 1, 32'h8000_0402);
      step("unal6", 0, 0, 0, 32'h0, 1, 32'h8000_0406);

      // PC wrap.
      step("toFFFC", 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
      step("wrap0", 0, 0, 0, 32'h0, 1, 32'h0000_0000);
      step("wrap4", 0, 0, 0, 32'h0, 1, 32'h0000_0004);

      // Reset in HOLD_PEND discards the pending redirect.
      step("hp_cap", 0, 1, 1, 32'h8000_0040, 1, 32'h0000_0004);
      step("hp_hold", 0, 1, 0, 32'h0, 1, 32'h0000_0004);
      step("hp_rst", 1, 1, 0, 32'h0, 0, 32'hBFBF_FFFC);
      step("boot_st", 0, 1, 0, 32'h0, 0, 32'hBFBF_FFFC);
      step("reboot", 0, 0, 0, 32'h0, 1, 32'hBFC0_0000);
      step("reboot4", 0, 0, 0, 32'h0, 1, 32'hBFC0_0004);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, issues reads to the instruction SRAM, and produces `if_to_id_bus` for the decode stage. It consumes the decode stage's `br_bus` redirect and the global `stall` vector. A redirect that arrives while the PC is stalled is captured in a pending register, so that redirect is never lost.

## Interface
- `RESET_VECTOR`, default 32'hBFC0_0000: address of the first instruction fetched after reset.
- `clk  in  1`: clock.
- `rst  in  1`: reset; synchronous, active-high.
- `stall  in  6`: global stall vector. Bit 0 = PC/IF hold (1 = Stop). Bits 5:1 are ignored here.
- `br_bus  in  33`: {br_e[32], br_addr[31:0]} from decode. `br_e` is a single-cycle-valid redirect request.
- `if_to_id_bus  out  33`: {ce[32], pc[31:0]} of the fetch currently presented to the SRAM.
- `inst_sram_en  out  1`: read enable; equals ce.
- `inst_sram_wen  out  4`: always 4'b0000.
- `inst_sram_addr  out  32`: equals pc.
- `inst_sram_wdata  out  32`: always 32'h0.

## Operation
- Registered state:
  - `pc_r[31:0]`, `ce_r`.
  - `pend_v`, `pend_addr[31:0]`.
  - 2-bit FSM `state`.
- All outputs are driven directly from registers, with no combinational path from inputs to outputs.
- FSM states:
  - BOOT: ce=0; only entered by reset.
  - RUN: fetching sequentially.
  - HOLD: stalled, no redirect pending.
  - HOLD_PEND: stalled, redirect pending.
- next_pc priority, evaluated only when `stall[0]`=0:
  1. live `br_e` → `br_addr`.
  2. otherwise `pend_v` → `pend_addr`.
  3. otherwise `pc_r` + 4 (mod 2^32; wraps FFFF_FFFC → 0000_0000).
- Transitions and actions:
  - BOOT → RUN on the first non-reset edge: `pc_r` <= next_pc, `ce_r` <= 1.
    - With no redirect, next_pc = RESET_VECTOR.
    - If `stall[0]`=1 at that edge, BOOT holds (ce stays 0).
  - RUN, `stall[0]`=0: `pc_r` <= next_pc, stay in RUN.
  - RUN, `stall[0]`=1, `br_e`=0: `pc_r` holds → HOLD.
  - RUN, `stall[0]`=1, `br_e`=1: `pc_r` holds; `pend_v` <= 1, `pend_addr` <= `br_addr` → HOLD_PEND.
  - HOLD, `stall[0]`=1: hold. If `br_e`=1, capture pending → HOLD_PEND.
  - HOLD, `stall[0]`=0: `pc_r` <= next_pc → RUN.
  - HOLD_PEND, `stall[0]`=1: hold. A new `br_e` overwrites `pend_addr` (latest redirect wins).
  - HOLD_PEND, `stall[0]`=0: `pc_r` <= next_pc (live `br_e` beats pending), `pend_v` <= 0 → RUN.
- Simultaneous `br_e` and `stall[0]`=0 in RUN: the redirect takes effect at that edge and no pending entry is created.
- `br_addr[1:0]` ≠ 0 is passed through unmodified; alignment faults are handled downstream.
- Reset values:
  - `pc_r` = RESET_VECTOR − 4; `ce_r` = 0.
  - `pend_v` = 0; `pend_addr` = 0.
  - `state` = BOOT.
  - Outputs at reset: `if_to_id_bus` = {1'b0, RESET_VECTOR−4}; `inst_sram_en` = 0; `inst_sram_addr` = RESET_VECTOR−4.
- `rst` asserted in any state, including HOLD_PEND: all state returns to reset values on that edge, and any pending redirect is discarded.

## Timing
- SRAM read is synchronous, one-cycle latency:
  - Cycle N: address `pc_r` is presented with en=1.
  - Cycle N+1: decode latches `if_to_id_bus` at the N→N+1 edge, and the instruction data for that address is valid at decode during N+1.
- Redirect latency: `br_e` sampled at edge E gives `inst_sram_addr` = `br_addr` in the cycle after E.
  - The instruction already in flight (the delay slot) is still delivered.
- Stall released at edge E: the pending or sequential address is presented in the cycle after E.
- While `stall[0]`=1, `inst_sram_addr` and `ce` are stable every cycle.

## Test plan
- Reset, then release with no stall:
  - The cycle after release shows `inst_sram_addr` = BFC0_0000, en=1.
  - The following three cycles show BFC0_0004, BFC0_0008, BFC0_000C.
- Running at pc=BFC0_0010, assert `br_e` with `br_addr`=BFC0_0100 for 1 cycle, no stall → next address BFC0_0100, then BFC0_0104.
- At pc=BFC0_0020, hold `stall[0]`=1 for 3 cycles → address stays BFC0_0020 for those cycles, then BFC0_0024 after release.
- At pc=BFC0_0030:
  - Assert `stall[0]`=1 and pulse `br_e` (addr 8000_0040) in stall cycle 2.
  - Release after stall cycle 4.
  - Required: address stays BFC0_0030 until release, next is 8000_0040, then 8000_0044.
- With a redirect pending to 8000_0040, release the stall in the same cycle as a new `br_e` to 8000_0080 → next address 8000_0080, `pend_v` clears.
- Set pc=FFFF_FFFC via redirect, run with no stall → next address 0000_0000.
- Reset mid-HOLD_PEND:
  - Assert `rst` while a redirect to 8000_0040 is pending.
  - Required: outputs return to ce=0 and address BFBF_FFFC.
  - After release, the first fetch is BFC0_0000, never 8000_0040.
